// File: rtl/voice_gate_sched.sv
// voice_gate_sched: 32-voice note allocator plus time-multiplexed gate scanner.
// Latency: a command transferred at clock T commits at T+33; cmd_ready returns at T+34.
// Backpressure: cmd_ready is high only while the allocator is idle; commands wait upstream.
//
// Optional feature macro: VOICE_STEAL_EN. When defined, a note-on that finds neither a
// matching nor a free voice steals the voice at a round-robin pointer; otherwise it drops.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_on/cmd_note note command (valid/ready)
//   ena, sel, GATE, frame_start        slot strobe, slot voice, its effective gate, frame pulse
//   alloc_valid/alloc_voice/alloc_note report of a note-on assignment or retrigger
//   drop                               command discarded (no match)
module voice_gate_sched #(
   parameter int VOICES    = 32,
   parameter int SLOT_CLKS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_on,
   input  logic [6:0] cmd_note,
   output logic       ena,
   output logic [4:0] sel,
   output logic       GATE,
   output logic       frame_start,
   output logic       alloc_valid,
   output logic [4:0] alloc_voice,
   output logic [6:0] alloc_note,
   output logic       drop
);

   localparam int            CW       = $clog2(SLOT_CLKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CLKS - 1);

   typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;

   // Per-voice tables
   logic [VOICES-1:0] gate_q;
   logic [VOICES-1:0] hold_q;
   logic [6:0]        note_q [VOICES];

   // Scanner
   logic          active;
   logic [CW-1:0] cnt;
   logic          slot_end;
   logic          gate_load;
   logic [4:0]    load_idx;
   logic          load_gate;
   logic          load_hold;
   logic          slot_hold;

   // Allocator
   state_t     state;
   state_t     state_nxt;
   logic       xfer;
   logic       cur_on;
   logic [6:0] cur_note;
   logic [4:0] scan_idx;
   logic       have_match;
   logic       have_free;
   logic [4:0] match_v;
   logic [4:0] free_v;

   // Table write port, driven only in COMMIT
   logic       wr_en;
   logic [4:0] wr_voice;
   logic [6:0] wr_note;
   logic       wr_gate;
   logic       wr_hold;

`ifdef VOICE_STEAL_EN
   logic [4:0] steal_ptr;
   logic       steal_adv;
`endif

   // ------------------------------------------------------------------
   // Slot scanner. 'active' holds the scanner off for the first edge after
   // reset release so that the first clock out of reset shows ena=1, sel=0.
   // ------------------------------------------------------------------
   assign slot_end    = active && (cnt == CNT_LAST);
   assign gate_load   = !active || slot_end;
   assign load_idx    = active ? sel + 5'd1 : sel;
   assign ena         = active && (cnt == '0);
   assign frame_start = ena && (sel == 5'd0);

   // GATE for the slot about to open is taken from the tables as they will
   // be after this edge, so a COMMIT on the boundary clock lands in that slot.
   assign load_gate = (wr_en && (wr_voice == load_idx)) ? wr_gate : gate_q[load_idx];
   assign load_hold = (wr_en && (wr_voice == load_idx)) ? wr_hold : hold_q[load_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active    <= 1'b0;
         cnt       <= '0;
         sel       <= '0;
         GATE      <= 1'b0;
         slot_hold <= 1'b0;
      end else begin
         active <= 1'b1;
         if (active) begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
         end
         if (slot_end) begin
            sel <= sel + 5'd1;
         end
         if (gate_load) begin
            GATE      <= load_gate & ~load_hold;
            // Remembers that this slot opened with hold set: it is the one
            // muted slot, and hold is released at its last clock.
            slot_hold <= load_hold;
         end
      end
   end

   // ------------------------------------------------------------------
   // Allocator FSM
   // ------------------------------------------------------------------
   assign xfer = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Linear search, one voice per clock; keeps the lowest hit of each kind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_on     <= 1'b0;
         cur_note   <= '0;
         scan_idx   <= '0;
         have_match <= 1'b0;
         have_free  <= 1'b0;
         match_v    <= '0;
         free_v     <= '0;
      end else if (xfer) begin
         cur_on     <= cmd_on;
         cur_note   <= cmd_note;
         scan_idx   <= '0;
         have_match <= 1'b0;
         have_free  <= 1'b0;
         match_v    <= '0;
         free_v     <= '0;
      end else if (state == SEARCH) begin
         if (!have_match && gate_q[scan_idx] && (note_q[scan_idx] == cur_note)) begin
            have_match <= 1'b1;
            match_v    <= scan_idx;
         end
         if (!have_free && !gate_q[scan_idx]) begin
            have_free <= 1'b1;
            free_v    <= scan_idx;
         end
         scan_idx <= scan_idx + 5'd1;
      end
   end

   always_comb begin
      state_nxt   = state;
      cmd_ready   = 1'b0;
      wr_en       = 1'b0;
      wr_voice    = '0;
      wr_note     = '0;
      wr_gate     = 1'b0;
      wr_hold     = 1'b0;
      alloc_valid = 1'b0;
      alloc_voice = '0;
      alloc_note  = '0;
      drop        = 1'b0;
`ifdef VOICE_STEAL_EN
      steal_adv   = 1'b0;
`endif
      case (state)
         IDLE: begin
            cmd_ready = active;
            if (cmd_valid && active) begin
               state_nxt = SEARCH;
            end
         end
         SEARCH: begin
            if (scan_idx == 5'd31) begin
               state_nxt = COMMIT;
            end
         end
         COMMIT: begin
            state_nxt = IDLE;
            if (cur_on) begin
               if (have_match) begin
                  // Retrigger: gate stays up, hold mutes one slot.
                  wr_en       = 1'b1;
                  wr_voice    = match_v;
                  wr_note     = cur_note;
                  wr_gate     = 1'b1;
                  wr_hold     = 1'b1;
                  alloc_valid = 1'b1;
                  alloc_voice = match_v;
                  alloc_note  = cur_note;
               end else if (have_free) begin
                  wr_en       = 1'b1;
                  wr_voice    = free_v;
                  wr_note     = cur_note;
                  wr_gate     = 1'b1;
                  wr_hold     = 1'b0;
                  alloc_valid = 1'b1;
                  alloc_voice = free_v;
                  alloc_note  = cur_note;
               end else begin
`ifdef VOICE_STEAL_EN
                  wr_en       = 1'b1;
                  wr_voice    = steal_ptr;
                  wr_note     = cur_note;
                  wr_gate     = 1'b1;
                  wr_hold     = 1'b1;
                  alloc_valid = 1'b1;
                  alloc_voice = steal_ptr;
                  alloc_note  = cur_note;
                  steal_adv   = 1'b1;
`else
                  drop        = 1'b1;
`endif
               end
            end else begin
               if (have_match) begin
                  wr_en    = 1'b1;
                  wr_voice = match_v;
                  wr_note  = cur_note;
                  wr_gate  = 1'b0;
                  wr_hold  = 1'b0;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Tables. The COMMIT write is last so it overrides a hold release that
   // targets the same voice on the same clock.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_q <= '0;
         hold_q <= '0;
         for (int v = 0; v < VOICES; v++) begin
            note_q[v] <= '0;
         end
      end else begin
         if (slot_end && slot_hold) begin
            hold_q[sel] <= 1'b0;
         end
         if (wr_en) begin
            gate_q[wr_voice] <= wr_gate;
            hold_q[wr_voice] <= wr_hold;
            note_q[wr_voice] <= wr_note;
         end
      end
   end

`ifdef VOICE_STEAL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         steal_ptr <= '0;
      end else if (steal_adv) begin
         steal_ptr <= steal_ptr + 5'd1;
      end
   end
`endif

endmodule

// File: tb/tb_voice_gate_sched.sv
// Testbench for voice_gate_sched.
// Drives note commands through valid/ready and follows the block with a cycle model.
// Ports: none (top level).
module tb_voice_gate_sched;

   localparam int SLOT = 4;
   localparam int NV   = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_on = 1'b0;
   logic [6:0] cmd_note = '0;
   logic       ena;
   logic [4:0] sel;
   logic       GATE;
   logic       frame_start;
   logic       alloc_valid;
   logic [4:0] alloc_voice;
   logic [6:0] alloc_note;
   logic       drop;

   voice_gate_sched #(.VOICES(NV), .SLOT_CLKS(SLOT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_on(cmd_on), .cmd_note(cmd_note),
      .ena(ena), .sel(sel), .GATE(GATE), .frame_start(frame_start),
      .alloc_valid(alloc_valid), .alloc_voice(alloc_voice), .alloc_note(alloc_note),
      .drop(drop)
   );

   always #10 clk = ~clk;

   typedef struct {bit on; bit [6:0] note;} cmd_t;
   cmd_t cmdq[$];

   int errs = 0;
   int checks = 0;

   // Reference model state
   int mcyc = -1;
   bit m_busy;
   int m_commit;
   int p_kind;   // 1 retrigger, 2 assign, 3 steal, 4 note-off, 5 drop
   int p_voice;
   int p_note;
   bit m_gate [NV];
   bit m_hold [NV];
   int m_note [NV];
   int m_steal;
   bit exp_gate;
   bit slot_low;

   // Observations
   logic [22:0] obs, expv, mask;
   int xfer_cyc, alloc_cyc, drop_cyc, drop_n, frame_n, last_note;
   int alloc_vq[$];
   bit g0q[$];

   task automatic model_reset();
      mcyc = -1; m_busy = 0; m_steal = 0; exp_gate = 0; slot_low = 0; p_kind = 0;
      for (int v = 0; v < NV; v++) begin
         m_gate[v] = 0; m_hold[v] = 0; m_note[v] = 0;
      end
      cmdq.delete();
      cmd_valid = 1'b0;
   endtask

   task automatic decide(input bit on, input int note);
      int hit;
      int fre;
      hit = -1; fre = -1;
      for (int v = NV - 1; v >= 0; v--) begin
         if (m_gate[v] && m_note[v] == note) hit = v;
         if (!m_gate[v]) fre = v;
      end
      p_note = note;
      p_voice = 0;
      if (on) begin
         if (hit >= 0) begin p_kind = 1; p_voice = hit; end
         else if (fre >= 0) begin p_kind = 2; p_voice = fre; end
         else begin
`ifdef VOICE_STEAL_EN
            p_kind = 3; p_voice = m_steal;
`else
            p_kind = 5;
`endif
         end
      end else if (hit >= 0) begin
         p_kind = 4; p_voice = hit;
      end else begin
         p_kind = 5;
      end
   endtask

   task automatic model_edge(output bit took);
      int c;
      int v;
      took = 1'b0;
      if (mcyc < 0) begin
         mcyc = 0;
         exp_gate = m_gate[0] && !m_hold[0];
         slot_low = m_hold[0];
      end else begin
         c = mcyc;
         if (cmd_valid && !m_busy) begin
            decide(cmd_on, int'(cmd_note));
            m_busy = 1; m_commit = c + 33; took = 1'b1;
         end
         if ((c % SLOT) == SLOT - 1 && slot_low) m_hold[(c / SLOT) % NV] = 0;
         if (m_busy && c == m_commit) begin
            case (p_kind)
               1: m_hold[p_voice] = 1;
               2: begin m_note[p_voice] = p_note; m_gate[p_voice] = 1; m_hold[p_voice] = 0; end
               3: begin
                  m_note[p_voice] = p_note; m_gate[p_voice] = 1; m_hold[p_voice] = 1;
                  m_steal = (m_steal + 1) % NV;
               end
               4: begin m_gate[p_voice] = 0; m_hold[p_voice] = 0; end
               default: ;
            endcase
            m_busy = 0;
         end
         mcyc = c + 1;
         if ((mcyc % SLOT) == 0) begin
            v = (mcyc / SLOT) % NV;
            exp_gate = m_gate[v] && !m_hold[v];
            slot_low = m_hold[v];
         end
      end
   endtask

   // One clock: present queued command, advance model at posedge, sample at negedge.
   task automatic tick();
      bit took;
      bit cn;
      bit av;
      cmd_t d;
      cmd_valid = (cmdq.size() > 0);
      if (cmdq.size() > 0) begin cmd_on = cmdq[0].on; cmd_note = cmdq[0].note; end
      @(posedge clk);
      took = 1'b0;
      if (rst_n) model_edge(took);
      if (took) begin d = cmdq.pop_front(); xfer_cyc = mcyc - 1; end
      @(negedge clk);
      obs = {cmd_ready, ena, sel, GATE, frame_start, alloc_valid, alloc_voice, alloc_note, drop};
      if (!rst_n || mcyc < 0) begin
         expv = '0; mask = '1;
      end else begin
         cn = m_busy && (mcyc == m_commit);
         av = cn && p_kind >= 1 && p_kind <= 3;
         expv = {!m_busy, (mcyc % SLOT) == 0, 5'((mcyc / SLOT) % NV), exp_gate,
                 (mcyc % (SLOT * NV)) == 0, av, av ? 5'(p_voice) : 5'd0,
                 av ? 7'(p_note) : 7'd0, cn && p_kind == 5};
         mask = av ? 23'h7FFFFF : ~23'h001FFE;
      end
      if (alloc_valid === 1'b1) begin
         alloc_vq.push_back(int'(alloc_voice)); alloc_cyc = mcyc; last_note = int'(alloc_note);
      end
      if (drop === 1'b1) begin drop_n++; drop_cyc = mcyc; end
      if (ena === 1'b1 && sel === 5'd0) g0q.push_back(GATE);
      if (frame_start === 1'b1) frame_n++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL reset_hold got=%h exp=%h", obs, expv);
         end
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({ena, sel, cmd_ready, GATE} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL reset_release ena=%b sel=%0d rdy=%b gate=%b exp 1 0 1 0", ena, sel, cmd_ready, GATE);
      end
      checks++;
      if ((obs & mask) !== (expv & mask)) begin
         errs++; $display("FAIL reset_first got=%h exp=%h", obs & mask, expv & mask);
      end
   endtask

   task automatic test_idle_scan();
      int n_ena;
      n_ena = 0; frame_n = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         if (ena === 1'b1) n_ena++;
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL idle_scan cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
         end
      end
      checks++;
      if (n_ena != 64 || frame_n != 2) begin
         errs++; $display("FAIL idle_counts ena=%0d frames=%0d exp 64 2", n_ena, frame_n);
      end
   endtask

   task automatic test_note_on();
      cmd_t c;
      alloc_vq.delete();
      c.on = 1; c.note = 7'd60; cmdq.push_back(c);
      for (int i = 0; i < 300; i++) begin
         tick();
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL note_on cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
         end
      end
      checks++;
      if (alloc_vq.size() != 1 || alloc_vq[0] != 0 || last_note != 60 || alloc_cyc - xfer_cyc != 33) begin
         errs++;
         $display("FAIL note_on_alloc n=%0d latency=%0d note=%0d exp 1 33 60", alloc_vq.size(), alloc_cyc - xfer_cyc, last_note);
      end
      checks++;
      if (g0q[g0q.size() - 1] !== 1'b1) begin
         errs++; $display("FAIL note_on_gate got=%b exp=1", g0q[g0q.size() - 1]);
      end
   endtask

   task automatic test_retrigger();
      cmd_t c;
      int start;
      int zeros;
      alloc_vq.delete();
      start = g0q.size();
      c.on = 1; c.note = 7'd60; cmdq.push_back(c);
      for (int i = 0; i < 300; i++) begin
         tick();
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL retrigger cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
         end
      end
      zeros = 0;
      for (int i = start; i < g0q.size(); i++) if (!g0q[i]) zeros++;
      checks++;
      if (alloc_vq.size() != 1 || alloc_vq[0] != 0 || zeros != 1 || g0q[g0q.size() - 1] !== 1'b1) begin
         errs++;
         $display("FAIL retrigger_result allocs=%0d zero_slots=%0d exp 1 1", alloc_vq.size(), zeros);
      end
   endtask

   task automatic test_note_off();
      cmd_t c;
      int d0;
      d0 = drop_n;
      c.on = 0; c.note = 7'd60; cmdq.push_back(c);
      for (int i = 0; i < 300; i++) begin
         tick();
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL note_off cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
         end
      end
      checks++;
      if (g0q[g0q.size() - 1] !== 1'b0 || drop_n != d0) begin
         errs++; $display("FAIL note_off_gate gate=%b drops=%0d exp 0 %0d", g0q[g0q.size() - 1], drop_n, d0);
      end
      c.on = 0; c.note = 7'd61; cmdq.push_back(c);
      for (int i = 0; i < 60; i++) begin
         tick();
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL note_off_nomatch cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
         end
      end
      checks++;
      if (drop_n != d0 + 1 || drop_cyc - xfer_cyc != 33) begin
         errs++; $display("FAIL drop_pulse drops=%0d latency=%0d exp %0d 33", drop_n - d0, drop_cyc - xfer_cyc, 1);
      end
   endtask

   task automatic test_fill();
      cmd_t c;
      bit ok;
      int d0;
      int owner;
      do_reset();
      alloc_vq.delete();
      drop_n = 0;
      for (int i = 0; i < 33; i++) begin c.on = 1; c.note = 7'(10 + i); cmdq.push_back(c); end
      for (int i = 0; i < 33 * 34 + 60; i++) begin
         tick();
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL fill cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
         end
      end
      ok = 1'b1;
      for (int i = 0; i < 32; i++) if (i >= alloc_vq.size() || alloc_vq[i] != i) ok = 1'b0;
      checks++;
      if (!ok) begin errs++; $display("FAIL fill_order allocs=%0d exp voices 0..31", alloc_vq.size()); end
`ifdef VOICE_STEAL_EN
      owner = 42;
      checks++;
      if (alloc_vq.size() != 33 || alloc_vq[alloc_vq.size() - 1] != 0 || last_note != 42 || drop_n != 0) begin
         errs++; $display("FAIL fill_steal allocs=%0d note=%0d drops=%0d exp 33 42 0", alloc_vq.size(), last_note, drop_n);
      end
`else
      owner = 10;
      checks++;
      if (alloc_vq.size() != 32 || drop_n != 1) begin
         errs++; $display("FAIL fill_drop allocs=%0d drops=%0d exp 32 1", alloc_vq.size(), drop_n);
      end
`endif
      d0 = drop_n;
      c.on = 0; c.note = 7'(owner); cmdq.push_back(c);
      for (int i = 0; i < 300; i++) begin
         tick();
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL fill_off cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
         end
      end
      checks++;
      if (drop_n != d0 || g0q[g0q.size() - 1] !== 1'b0) begin
         errs++; $display("FAIL voice0_owner drops=%0d gate=%b exp %0d 0", drop_n, g0q[g0q.size() - 1], d0);
      end
   endtask

   task automatic test_reset_mid_search();
      cmd_t c;
      do_reset();
      c.on = 1; c.note = 7'd70; cmdq.push_back(c);
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
         end
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, ena, sel, GATE, frame_start, alloc_valid, alloc_voice, alloc_note, drop} !== 23'd0) begin
         errs++; $display("FAIL async_reset got=%h exp=0", {cmd_ready, ena, sel, GATE, frame_start, alloc_valid, alloc_voice, alloc_note, drop});
      end
      model_reset();
      tick(); tick();
      rst_n = 1'b1;
      alloc_vq.delete();
      frame_n = 0;
      for (int i = 0; i < 257; i++) begin
         tick();
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
         end
      end
      checks++;
      if (alloc_vq.size() != 0 || frame_n != 3) begin
         errs++; $display("FAIL post_reset_counts allocs=%0d frames=%0d exp 0 3", alloc_vq.size(), frame_n);
      end
   endtask

   task automatic test_random();
      cmd_t c;
      do_reset();
      for (int k = 0; k < 60; k++) begin
         c.on = ($urandom_range(0, 99) < 60);
         c.note = 7'(60 + $urandom_range(0, 3));
         cmdq.push_back(c);
         for (int i = 0; i < 34 + int'($urandom_range(0, 10)); i++) begin
            tick();
            checks++;
            if ((obs & mask) !== (expv & mask)) begin
               errs++; $display("FAIL random cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
            end
         end
      end
      for (int i = 0; i < 300; i++) begin
         tick();
         checks++;
         if ((obs & mask) !== (expv & mask)) begin
            errs++; $display("FAIL random_tail cyc=%0d got=%h exp=%h", mcyc, obs & mask, expv & mask);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_idle_scan();
      test_note_on();
      test_retrigger();
      test_note_off();
      test_fill();
      test_reset_mid_search();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
